// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and helpers for the FIR requantiser path
// Purpose: sample widths used by the FIR, the requantiser/FIFO block and benches.
// Ports: none (package).
package fir_pkg;
  localparam int FIR_X_W = 8;            // FIR input sample width
  localparam int FIR_Y_W = 19;           // FIR accumulator output width (unsigned)
  localparam int OUT_W   = 8;            // requantised output width
  localparam int ACC_W   = FIR_Y_W + 1;  // rounding sum width, keeps the carry

  // Clip an unsigned rounded value to the OUT_W range.
  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] z);
    if (z > ACC_W'({OUT_W{1'b1}})) begin
      return {OUT_W{1'b1}};
    end
    return z[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - synchronous FIFO with registered head output
// Purpose: power-of-two depth FIFO; dout is a register that shows the head
//          entry and holds the last shown value when the FIFO drains.
// Ports: clk, rst (async, active-high); wr_en/din write side; rd_en/dout read
//        side; level occupancy 0..DEPTH; full/empty status.
module fir_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_ok, wr_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + LW'(1);
    end else if (rd_ok && !wr_ok) begin
      level_d = level_q - LW'(1);
    end
    // Next head: the incoming word when it becomes the only entry, otherwise
    // the entry behind the popped one; an emptied FIFO keeps the old value.
    dout_d = dout_q;
    if (empty) begin
      if (wr_ok) dout_d = din;
    end else if (rd_ok) begin
      if (level_q == LW'(1)) begin
        if (wr_ok) dout_d = din;
      end else begin
        dout_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign level = level_q;
endmodule

// File: rtl/fir_requant_fifo.sv
// rtl/fir_requant_fifo.sv - round, shift and saturate FIR results into a FIFO
// Purpose: stage 1 registers the rounded, shifted FIR result; stage 2 clips it
//          to 8 bits and writes it to the output FIFO, tracking drops and
//          saturations in sticky/counting flags.
// Ports: clock, reset (async, active-high); valid_in/y FIR side (no
//        backpressure); m_data/m_valid/m_ready consumer side; clr_flags,
//        overflow, sat_count status; level FIFO occupancy.
module fir_requant_fifo
  import fir_pkg::*;
#(
  parameter int SHIFT = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [FIR_Y_W-1:0]         y,
  output logic [OUT_W-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       clr_flags,
  output logic                       overflow,
  output logic [7:0]                 sat_count,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);

  logic [ACC_W-1:0] z_d, z_q;
  logic             s1_vld_q;
  logic             sat, pop, full, empty, wr_drop, wr_acc;
  logic             overflow_q, overflow_d;
  logic [7:0]       sat_count_q, sat_count_d;

  // One extra bit so the rounding add cannot lose its carry.
  assign z_d = (ACC_W'(y) + RND) >> SHIFT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      z_q      <= '0;
    end else begin
      s1_vld_q <= valid_in;
      if (valid_in) z_q <= z_d;
    end
  end

  assign sat     = (z_q > ACC_W'({OUT_W{1'b1}}));
  assign pop     = m_valid & m_ready;
  assign wr_drop = s1_vld_q & full & ~pop;
  assign wr_acc  = s1_vld_q & ~wr_drop;

  fir_sync_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clock),
    .rst  (reset),
    .wr_en(s1_vld_q),
    .din  (sat_out(z_q)),
    .rd_en(pop),
    .dout (m_data),
    .level(level),
    .full (full),
    .empty(empty)
  );

  assign m_valid = ~empty;

  // clr_flags wins over a same-edge drop or saturation; that event is lost.
  always_comb begin
    overflow_d  = overflow_q;
    sat_count_d = sat_count_q;
    if (clr_flags) begin
      overflow_d  = 1'b0;
      sat_count_d = '0;
    end else begin
      if (wr_drop) overflow_d = 1'b1;
      if (wr_acc && sat && sat_count_q != 8'hFF) sat_count_d = sat_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign overflow  = overflow_q;
  assign sat_count = sat_count_q;
endmodule

// File: tb/tb_fir_requant_fifo.sv
// tb/tb_fir_requant_fifo.sv - self-checking bench for fir_requant_fifo
module tb_fir_requant_fifo;
  import fir_pkg::*;

  localparam int SHIFT = 11;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               valid_in = 1'b0;
  logic [FIR_Y_W-1:0] y = '0;
  logic [OUT_W-1:0]   m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               clr_flags = 1'b0;
  logic               overflow;
  logic [7:0]         sat_count;
  logic [LW-1:0]      level;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mq[$];
  bit pend_v;
  int pend_z;
  bit m_ovf;
  int m_sat;
  int m_hold;
  int popped[$];

  always #5 clock = ~clock;

  fir_requant_fifo #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .valid_in (valid_in),
    .y        (y),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .clr_flags(clr_flags),
    .overflow (overflow),
    .sat_count(sat_count),
    .level    (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_v = 1'b0;
    pend_z = 0;
    m_ovf  = 1'b0;
    m_sat  = 0;
    m_hold = 0;
  endtask

  // One clock edge of the intended behaviour, from pre-edge state and inputs.
  task automatic model_edge(input bit v, input int yy, input bit rdy, input bit clr);
    bit pop;
    bit acc;
    int tmp;
    pop = (mq.size() != 0) && rdy;
    acc = pend_v && ((mq.size() < DEPTH) || pop);
    if (pop) tmp = mq.pop_front();
    if (acc) mq.push_back((pend_z > 255) ? 255 : pend_z);
    if (clr) begin
      m_ovf = 1'b0;
      m_sat = 0;
    end else begin
      if (pend_v && !acc) m_ovf = 1'b1;
      if (acc && pend_z > 255 && m_sat < 255) m_sat++;
    end
    pend_v = v;
    pend_z = (yy + (1 << (SHIFT - 1))) >> SHIFT;
    if (mq.size() != 0) m_hold = mq[0];
  endtask

  task automatic check_all();
    chk("m_valid", m_valid, (mq.size() != 0) ? 1 : 0);
    chk("level", level, mq.size());
    chk("m_data", m_data, m_hold);
    chk("overflow", overflow, m_ovf);
    chk("sat_count", sat_count, m_sat);
  endtask

  task automatic step(input bit v, input int yy, input bit rdy, input bit clr = 1'b0);
    valid_in  = v;
    y         = yy[FIR_Y_W-1:0];
    m_ready   = rdy;
    clr_flags = clr;
    if (m_valid && rdy) popped.push_back(int'(m_data));
    @(posedge clock);
    model_edge(v, yy, rdy, clr);
    #1;
    check_all();
  endtask

  initial begin
    int exp_r[4];
    int yy;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sat_count", sat_count, 0);
    reset = 1'b0;

    // Rounding with latency
    popped.delete();
    step(1, 1023, 1);
    chk("lat_first_edge", m_valid, 0);
    step(1, 1024, 1);
    chk("lat_second_edge", m_valid, 1);
    step(1, 3071, 1);
    step(1, 3072, 1);
    repeat (3) step(0, 0, 1);
    exp_r = '{0, 1, 1, 2};
    chk("round_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("round_data", popped[i], exp_r[i]);

    // Saturation
    popped.delete();
    step(1, 524287, 1);
    step(1, 524287, 1);
    repeat (3) step(0, 0, 1);
    chk("sat_count_two", sat_count, 2);
    chk("sat_pop_count", popped.size(), 2);
    for (int i = 0; i < popped.size(); i++) chk("sat_data", popped[i], 255);

    // Overflow: 6 samples into a stalled FIFO
    popped.delete();
    for (int k = 1; k <= 6; k++) step(1, k * 2048, 0);
    step(0, 0, 0);
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    repeat (6) step(0, 0, 1);
    chk("ovf_pop_count", popped.size(), 4);
    for (int i = 0; i < popped.size(); i++) chk("ovf_order", popped[i], i + 1);

    // Flag clear against a same-edge saturated write
    step(1, 524287, 1);
    step(0, 0, 1);
    chk("pre_clr_sat", sat_count, 3);
    chk("pre_clr_ovf", overflow, 1);
    step(0, 0, 1);
    step(1, 524287, 1);
    step(0, 0, 1, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_sat", sat_count, 0);
    repeat (2) step(0, 0, 1);

    // Full plus pop under a continuous stream
    popped.delete();
    for (int k = 0; k < 5; k++) step(1, $urandom_range(0, 524287), 0);
    chk("fp_full", level, DEPTH);
    for (int k = 0; k < 10; k++) begin
      step(1, $urandom_range(0, 524287), 1);
      chk("fp_level", level, DEPTH);
      chk("fp_ovf", overflow, 0);
    end
    repeat (7) step(0, 0, 1);
    chk("fp_pop_count", popped.size(), 15);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      yy = ($urandom_range(0, 3) == 0) ? $urandom_range(520000, 524287) : $urandom_range(0, 524287);
      step($urandom_range(0, 2) != 0, yy, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Mid-run reset with level 3 and one sample in flight
    step(1, 0, 1, 1);
    repeat (DEPTH + 1) step(0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 4096, 0);
    chk("mid_level3", level, 3);
    reset = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("mid_m_valid", m_valid, 0);
    chk("mid_level", level, 0);
    chk("mid_m_data", m_data, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    step(0, 0, 1);
    chk("post_rst_empty", m_valid, 0);
    step(1, 2048, 1);
    step(0, 0, 1);
    chk("fresh_valid", m_valid, 1);
    chk("fresh_data", m_data, 1);
    step(0, 0, 1);
    chk("fresh_drained", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_requant_fifo.md
FIR_REQUANT_FIFO -- requirements
Module: fir_requant_fifo

Interface
REQ-001 The block SHALL have parameter SHIFT, default 11, the right-shift applied to the FIR output before requantisation.
REQ-002 The block SHALL have parameter DEPTH, default 4, the FIFO depth in samples; it is a power of two, at least 2.
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port valid_in  input  1  FIR output strobe; there is no backpressure toward the FIR.
REQ-006 The block SHALL have port y  input  19  unsigned FIR result, sampled when valid_in=1.
REQ-007 The block SHALL have port m_data  output  8  head-of-FIFO requantised sample.
REQ-008 The block SHALL have port m_valid  output  1  FIFO non-empty.
REQ-009 The block SHALL have port m_ready  input  1  consumer accepts m_data when m_valid&m_ready.
REQ-010 The block SHALL have port clr_flags  input  1  synchronous clear of overflow and sat_count.
REQ-011 The block SHALL have port overflow  output  1  sticky flag: a sample was dropped.
REQ-012 The block SHALL have port sat_count  output  8  count of saturated samples; holds at 255.
REQ-013 The block SHALL have port level  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 Stage 1 SHALL register z = (y + 2^(SHIFT-1)) >> SHIFT, computed in 20 bits so there is no carry loss, on each edge where valid_in=1, with a stage-valid bit.
REQ-015 Saturation SHALL output 255 when z > 255, otherwise z[7:0]; each saturated sample written to the FIFO increments sat_count unless it is already 255.
REQ-016 Stage 2 SHALL write a valid stage-1 sample into the FIFO on the next edge, so m_valid rises two edges after the valid_in edge when the FIFO is empty.
REQ-017 A pop SHALL occur on an edge where m_valid&m_ready; m_data then shows the next entry, or holds the last value with m_valid=0.
REQ-018 A write SHALL occur when level<DEPTH, or when level==DEPTH and a pop happens on the same edge; in the full-plus-pop case, level stays at DEPTH.
REQ-019 A write attempt with level==DEPTH and no pop SHALL drop the sample, set overflow, leave FIFO contents and level unchanged, and not count saturation.
REQ-020 Simultaneous write and pop at any level SHALL leave level unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; the ordering is strictly FIFO.
REQ-022 clr_flags SHALL take priority over a same-edge overflow or saturation event: the flags read 0 next cycle and the event is lost.
REQ-023 m_valid SHALL equal (level != 0); m_data SHALL be the registered head, stable while m_valid&!m_ready.

Reset
REQ-024 Reset SHALL asynchronously clear the stage-valid bit, the pointers, level, overflow and sat_count to 0, which gives m_valid=0.
REQ-025 m_data SHALL be 0 after reset.
REQ-026 Reset asserted mid-operation SHALL discard all buffered and in-flight samples; no write occurs on the edge where reset deasserts.

Structure
REQ-027 Package fir_pkg SHALL hold FIR_X_W=8, FIR_Y_W=19 and OUT_W=8, shared with the fir block and benches.
REQ-028 Storage and pointers SHALL live in sub-module fir_sync_fifo (params WIDTH, DEPTH; ports wr_en, din, rd_en, dout, level, full, empty).
REQ-029 Requantisation, flags and the stage-1 register SHALL live in the top module.

Verification
REQ-030 Rounding: with SHIFT=11 and m_ready=1, send y=1023, 1024, 3071, 3072; the bench SHALL see m_data 0, 1, 1, 2, in order, with m_valid two edges after each input.
REQ-031 Saturation: send y=524287 and y=600000>>0 clipped to 524287 twice; the bench SHALL see m_data 255 twice and sat_count=2.
REQ-032 Overflow: with m_ready=0, send 6 consecutive samples with DEPTH=4; the bench SHALL see level=4, overflow=1, and the first 4 samples popped in order once m_ready=1.
REQ-033 Full plus pop: with the FIFO full and m_ready=1, send a continuous valid_in stream; the bench SHALL see level stay at 4, overflow stay 0, and no samples lost.
REQ-034 Flag clear: with overflow=1 and sat_count=3, pulse clr_flags on the same edge as a saturated write; the bench SHALL see overflow=0 and sat_count=0.
REQ-035 Mid-run reset: assert reset with level=3; the bench SHALL see m_valid=0 and level=0 immediately, and a fresh sample y=2048 emerge as m_data=1.
